rf_wb_arbiter: RTL and testbench

Shares the register bank's single write port between two writeback requesters: A (ALU) and B (load unit).
Each requester uses a valid/ready handshake. Grants are round-robin, and the accepted write is registered onto the bank's write-enable/address/data inputs.
A per-register busy scoreboard tracks destinations allocated at issue and clears them when their write commits. The decode stage queries it to stall on read-after-write hazards.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 103 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback path.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int NREG   = 16;
  localparam int IDX_W  = $clog2(NREG);

  // Round-robin pointer encoding: which requester wins the next contention.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // True when the address names an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(NREG);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared when the write commits,
// queried combinationally by decode. Allocation wins over a same-edge clear.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear the committed register first, then apply the allocation.
  always_comb begin
    // NOTE: start from the current value so every path assigns busy_d; no latch is inferred.
    busy_d = busy_q;
    if (clr_en && addr_in_range(clr_addr)) begin
      busy_d[clr_addr[IDX_W-1:0]] = 1'b0;
    end
    if (set_en && addr_in_range(set_addr)) begin
      busy_d[set_addr[IDX_W-1:0]] = 1'b1;
    end
  end

  // Busy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this vector is flag state, not data storage, so it must be reset; a stale busy bit would stall decode forever.
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      busy_q <= busy_d;
    end
  end

  assign q_busy1 = addr_in_range(q_addr1) && busy_q[q_addr1[IDX_W-1:0]];
  assign q_busy2 = addr_in_range(q_addr2) && busy_q[q_addr2[IDX_W-1:0]];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port between the ALU (A)
// and the load unit (B). The accepted write is registered onto the bank inputs;
// out-of-range destinations are accepted but dropped with a one-cycle wb_err.
module rf_wb_arbiter
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wb_err
);

  req_id_e           rr_ptr;
  logic              grant_a;
  logic              grant_b;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_ok;

  // Grant: freeze blocks everything, a lone requester always wins, rr_ptr breaks ties.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!freeze) begin
      if (a_valid && b_valid) begin
        grant_a = (rr_ptr == REQ_A);
        grant_b = (rr_ptr == REQ_B);
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // A grant is only ever given to a valid requester, so grant == handshake.
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign grant_any = grant_a | grant_b;
  assign sel_addr  = grant_b ? b_addr : a_addr;
  assign sel_data  = grant_b ? b_data : a_data;
  assign sel_ok    = addr_in_range(sel_addr);

  // Round-robin pointer: hand priority to the other requester after each handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= REQ_A;
    end else if (grant_a) begin
      rr_ptr <= REQ_B;
    end else if (grant_b) begin
      rr_ptr <= REQ_A;
    end
  end

  // Bank write register: pulse wr_en for in-range writes, wb_err for dropped ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wb_err  <= 1'b0;
    end else begin
      wr_en  <= grant_any && sel_ok;
      wb_err <= grant_any && !sel_ok;
      if (grant_any && sel_ok) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  // Busy bits clear on the same edge the bank captures the write.
  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (alloc_valid),
    .set_addr (alloc_addr),
    .clr_en   (wr_en),
    .clr_addr (wr_addr),
    .q_addr1  (q_addr1),
    .q_addr2  (q_addr2),
    .q_busy1  (q_busy1),
    .q_busy2  (q_busy2)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, a mid-run reset sequence,
// then random traffic compared against a behavioural model.
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              freeze;
  logic              a_valid, a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid, b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              alloc_valid;
  logic [ADDR_W-1:0] alloc_addr;
  logic [ADDR_W-1:0] q_addr1, q_addr2;
  logic              q_busy1, q_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .freeze      (freeze),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .q_addr1     (q_addr1),
    .q_addr2     (q_addr2),
    .q_busy1     (q_busy1),
    .q_busy2     (q_busy2),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wb_err      (wb_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Requesters must hold valid/addr/data while stalled.
  logic              a_hold, b_hold;
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  always @(posedge clk) begin
    if (rst_n && a_hold)
      assert (a_valid && a_addr == a_addr_q && a_data == a_data_q)
        else $error("protocol violation on requester A");
    if (rst_n && b_hold)
      assert (b_valid && b_addr == b_addr_q && b_data == b_data_q)
        else $error("protocol violation on requester B");
    a_hold   <= rst_n && a_valid && !a_ready;
    b_hold   <= rst_n && b_valid && !b_ready;
    a_addr_q <= a_addr;
    a_data_q <= a_data;
    b_addr_q <= b_addr;
    b_data_q <= b_data;
  end

  typedef struct {
    logic              fz, av;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [DATA_W-1:0] bd;
    logic              alv;
    logic [ADDR_W-1:0] ala, q1, q2;
    logic              ar, br, bz1, bz2;
    logic              wen;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              werr;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  function automatic vec_t mk(
    input logic [31:0] fz, av, aa, ad, bv, ba, bd, alv, ala, q1, q2,
    input logic [31:0] ar, br, bz1, bz2, wen, wa, wd, werr);
    vec_t v;
    v.fz = fz[0]; v.av = av[0]; v.aa = aa[ADDR_W-1:0]; v.ad = ad;
    v.bv = bv[0]; v.ba = ba[ADDR_W-1:0]; v.bd = bd;
    v.alv = alv[0]; v.ala = ala[ADDR_W-1:0];
    v.q1 = q1[ADDR_W-1:0]; v.q2 = q2[ADDR_W-1:0];
    v.ar = ar[0]; v.br = br[0]; v.bz1 = bz1[0]; v.bz2 = bz2[0];
    v.wen = wen[0]; v.wa = wa[ADDR_W-1:0]; v.wd = wd; v.werr = werr[0];
    return v;
  endfunction

  // Behavioural model state for the random phase.
  bit                m_wen, m_err, pref_b;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit                busy_m[NREG];

  function automatic bit model_busy(input logic [ADDR_W-1:0] addr);
    int idx = int'(addr);
    return (idx < NREG) ? busy_m[idx] : 1'b0;
  endfunction

  task automatic idle_inputs();
    freeze = 0; a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    alloc_valid = 0; alloc_addr = 0; q_addr1 = 0; q_addr2 = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ga, gb;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;

    //                 fz av aa  ad            bv ba  bd        alv ala q1  q2  ar br z1 z2 wen wa  wd            werr
    vecs[0]  = mk(0, 0, 0,  0,            0, 0,  0,        0, 0,  0,  0,  0, 0, 0, 0, 0, 0,  0,            0);
    vecs[1]  = mk(0, 1, 3,  'hDEADBEEF,   0, 0,  0,        0, 0,  0,  0,  1, 0, 0, 0, 1, 3,  'hDEADBEEF,   0);
    vecs[2]  = mk(0, 0, 0,  0,            1, 7,  'h77,     0, 0,  0,  0,  0, 1, 0, 0, 1, 7,  'h77,         0);
    vecs[3]  = mk(0, 1, 1,  'h11,         1, 2,  'h22,     0, 0,  0,  0,  1, 0, 0, 0, 1, 1,  'h11,         0);
    vecs[4]  = mk(0, 1, 3,  'h33,         1, 2,  'h22,     0, 0,  0,  0,  0, 1, 0, 0, 1, 2,  'h22,         0);
    vecs[5]  = mk(0, 1, 3,  'h33,         1, 4,  'h44,     0, 0,  0,  0,  1, 0, 0, 0, 1, 3,  'h33,         0);
    vecs[6]  = mk(0, 1, 5,  'h55,         1, 4,  'h44,     0, 0,  0,  0,  0, 1, 0, 0, 1, 4,  'h44,         0);
    vecs[7]  = mk(1, 1, 5,  'h55,         1, 6,  'h66,     0, 0,  0,  0,  0, 0, 0, 0, 0, 4,  'h44,         0);
    vecs[8]  = mk(1, 1, 5,  'h55,         1, 6,  'h66,     0, 0,  0,  0,  0, 0, 0, 0, 0, 4,  'h44,         0);
    vecs[9]  = mk(0, 1, 5,  'h55,         1, 6,  'h66,     0, 0,  0,  0,  1, 0, 0, 0, 1, 5,  'h55,         0);
    vecs[10] = mk(0, 0, 0,  0,            1, 6,  'h66,     1, 9,  9,  0,  0, 1, 0, 0, 1, 6,  'h66,         0);
    vecs[11] = mk(0, 0, 0,  0,            0, 0,  0,        1, 20, 9,  4,  0, 0, 1, 0, 0, 6,  'h66,         0);
    vecs[12] = mk(0, 0, 0,  0,            1, 9,  'h99,     0, 0,  9,  4,  0, 1, 1, 0, 1, 9,  'h99,         0);
    vecs[13] = mk(0, 0, 0,  0,            0, 0,  0,        0, 0,  9,  0,  0, 0, 1, 0, 0, 9,  'h99,         0);
    vecs[14] = mk(0, 0, 0,  0,            0, 0,  0,        1, 9,  9,  0,  0, 0, 0, 0, 0, 9,  'h99,         0);
    vecs[15] = mk(0, 0, 0,  0,            1, 9,  'hA9,     0, 0,  9,  0,  0, 1, 1, 0, 1, 9,  'hA9,         0);
    vecs[16] = mk(0, 0, 0,  0,            0, 0,  0,        1, 9,  9,  0,  0, 0, 1, 0, 0, 9,  'hA9,         0);
    vecs[17] = mk(0, 1, 20, 'h20,         0, 0,  0,        0, 0,  9,  0,  1, 0, 1, 0, 0, 9,  'hA9,         1);
    vecs[18] = mk(0, 0, 0,  0,            0, 0,  0,        0, 0,  25, 9,  0, 0, 0, 1, 0, 9,  'hA9,         0);
    vecs[19] = mk(0, 1, 10, 'h1010,       1, 11, 'h1111,   0, 0,  0,  0,  0, 1, 0, 0, 1, 11, 'h1111,       0);
    vecs[20] = mk(0, 1, 10, 'h1010,       0, 0,  0,        0, 0,  0,  0,  1, 0, 0, 0, 1, 10, 'h1010,       0);
    vecs[21] = mk(0, 0, 0,  0,            0, 0,  0,        0, 0,  10, 11, 0, 0, 0, 0, 0, 10, 'h1010,       0);

    // Reset state.
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset wr_en",   32'(wr_en),   0);
    check("reset wr_addr", 32'(wr_addr), 0);
    check("reset wr_data", wr_data,      0);
    check("reset wb_err",  32'(wb_err),  0);
    check("reset a_ready", 32'(a_ready), 0);
    check("reset b_ready", 32'(b_ready), 0);
    @(negedge clk);
    rst_n = 1;

    // Directed vector table, one row per cycle.
    for (int i = 0; i < NVEC; i++) begin
      freeze = vecs[i].fz;
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      alloc_valid = vecs[i].alv; alloc_addr = vecs[i].ala;
      q_addr1 = vecs[i].q1; q_addr2 = vecs[i].q2;
      #1;
      check($sformatf("row%0d a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
      check($sformatf("row%0d b_ready", i), 32'(b_ready), 32'(vecs[i].br));
      check($sformatf("row%0d q_busy1", i), 32'(q_busy1), 32'(vecs[i].bz1));
      check($sformatf("row%0d q_busy2", i), 32'(q_busy2), 32'(vecs[i].bz2));
      @(posedge clk);
      #1;
      check($sformatf("row%0d wr_en", i),  32'(wr_en),  32'(vecs[i].wen));
      check($sformatf("row%0d wb_err", i), 32'(wb_err), 32'(vecs[i].werr));
      if (!vecs[i].werr) begin
        check($sformatf("row%0d wr_addr", i), 32'(wr_addr), 32'(vecs[i].wa));
        check($sformatf("row%0d wr_data", i), wr_data, vecs[i].wd);
      end
      @(negedge clk);
    end

    // Asynchronous reset while a write is on the bank port and a register is busy.
    idle_inputs();
    a_valid = 1; a_addr = 2; a_data = 'hCAFE;
    alloc_valid = 1; alloc_addr = 5; q_addr1 = 5; q_addr2 = 2;
    @(posedge clk);
    #1;
    a_valid = 0; alloc_valid = 0;
    check("pre-reset wr_en",   32'(wr_en),   1);
    check("pre-reset q_busy1", 32'(q_busy1), 1);
    #1 rst_n = 0;
    #1;
    check("mid-reset wr_en",   32'(wr_en),   0);
    check("mid-reset wb_err",  32'(wb_err),  0);
    check("mid-reset wr_addr", 32'(wr_addr), 0);
    check("mid-reset q_busy1", 32'(q_busy1), 0);
    check("mid-reset a_ready", 32'(a_ready), 0);
    check("mid-reset b_ready", 32'(b_ready), 0);
    @(negedge clk);
    rst_n = 1;
    // Pointer was at B before reset; the first contention must go to A.
    a_valid = 1; a_addr = 1; a_data = 'h1;
    b_valid = 1; b_addr = 2; b_data = 'h2;
    #1;
    check("post-reset a_ready", 32'(a_ready), 1);
    check("post-reset b_ready", 32'(b_ready), 0);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1;

    // Random traffic against the model.
    m_wen = 0; m_err = 0; pref_b = 0; m_waddr = 0; m_wdata = 0;
    foreach (busy_m[i]) busy_m[i] = 0;
    ga = 0; gb = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ga) a_valid = 0;
      if (gb) b_valid = 0;
      check("rand wr_en",  32'(wr_en),  32'(m_wen));
      check("rand wb_err", 32'(wb_err), 32'(m_err));
      if (!m_err) begin
        check("rand wr_addr", 32'(wr_addr), 32'(m_waddr));
        check("rand wr_data", wr_data, m_wdata);
      end
      if (!a_valid && $urandom_range(0, 9) < 6) begin
        a_valid = 1; a_addr = ADDR_W'($urandom_range(0, 19)); a_data = $urandom;
      end
      if (!b_valid && $urandom_range(0, 9) < 6) begin
        b_valid = 1; b_addr = ADDR_W'($urandom_range(0, 19)); b_data = $urandom;
      end
      freeze      = ($urandom_range(0, 7) == 0);
      alloc_valid = ($urandom_range(0, 2) == 0);
      alloc_addr  = ADDR_W'($urandom_range(0, 19));
      q_addr1     = ADDR_W'($urandom_range(0, 19));
      q_addr2     = ADDR_W'($urandom_range(0, 19));
      #1;
      ga = 0; gb = 0;
      if (!freeze) begin
        if (a_valid && b_valid) begin
          gb = pref_b;
          ga = !pref_b;
        end else begin
          ga = a_valid;
          gb = b_valid;
        end
      end
      check("rand a_ready", 32'(a_ready), 32'(ga));
      check("rand b_ready", 32'(b_ready), 32'(gb));
      check("rand q_busy1", 32'(q_busy1), 32'(model_busy(q_addr1)));
      check("rand q_busy2", 32'(q_busy2), 32'(model_busy(q_addr2)));
      @(posedge clk);
      if (m_wen) busy_m[int'(m_waddr)] = 0;
      if (alloc_valid && int'(alloc_addr) < NREG) busy_m[int'(alloc_addr)] = 1;
      if (ga || gb) begin
        g_addr = ga ? a_addr : b_addr;
        g_data = ga ? a_data : b_data;
        if (int'(g_addr) < NREG) begin
          m_wen = 1; m_err = 0; m_waddr = g_addr; m_wdata = g_data;
        end else begin
          m_wen = 0; m_err = 1;
        end
        pref_b = ga;
      end else begin
        m_wen = 0; m_err = 0;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
